braille_writer: RTL and testbench
=================================

// Module: braille_writer
// PURPOSE
//  Transmit side of the braille cell stream. Captures braille cells one at a time from dot switches into a
//  message buffer, then streams the message to the braille reader stage on a send press.
//  Output framing is one header cycle followed by N data cycles on braille_out/braille_size/braille_valid.
//  It is the producer for the reader's IDLE->LOADING capture.
// PARAMETERS
//  MAX_CELLS  255  buffer capacity in cells; must be 1..255 because braille_size is 8 bits
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous reset, active-high
//  dots_in       in   8  dot switches, bit0=dot1 .. bit7=dot8
//  enter         in   1  button; a falling edge commits dots_in as the next cell
//  erase         in   1  button; a falling edge removes the last committed cell
//  send          in   1  button; a falling edge streams the buffer out
//  braille_out   out  8  stream data byte
//  braille_size  out  8  cell count of the message; held stable for the whole stream
//  braille_valid out  1  high during the header cycle and all data cycles
//  echo_out      out  8  last committed cell; 0 when the buffer is empty
//  cell_count    out  8  cells currently in the buffer
//  full          out  1  cell_count == MAX_CELLS
//  busy          out  1  state != IDLE
// BEHAVIOUR
//  - Reset values: all outputs 0, state IDLE, cell_count 0, button sync/prev flops 0. Buffer RAM is not reset.
//  - Buttons pass through a 2-flop sync (prev<=sync, sync<=in). event = prev & ~sync.
//    Event fires 2 clk after the falling edge and lasts 1 cycle.
//    A button held through reset produces an event on its release.
//  - IDLE:
//    - erase event with cell_count>0: cell_count-1.
//    - else enter event with !full: buf[cell_count] <= masked dots_in, cell_count+1.
//    - enter while full: ignored.
//    - erase while empty: ignored.
//    - erase and enter in the same cycle: erase wins, enter is dropped.
//    - send event with cell_count>0: go to HEADER and latch braille_size<=cell_count.
//    - send while empty: ignored, remain IDLE.
//    - send takes priority over enter/erase in the same cycle; those are dropped.
//  - HEADER (1 cycle): braille_valid=1, braille_out=8'h00 (the reader ignores it). rd_idx<=0. Go to STREAM.
//  - STREAM: braille_valid=1, braille_out=buf[rd_idx], rd_idx+1 each cycle.
//    After data cycle braille_size-1, go to DONE.
//  - DONE (1 cycle): braille_valid=0, braille_out=0, cell_count<=0 (message consumed), braille_size<=0. Go to IDLE.
//  - All button events are ignored in HEADER/STREAM/DONE.
//  - Stream length is exactly 1+N valid cycles, back to back, with no stalls.
//  - Outputs are registered: valid/data change on the clk edge that enters HEADER/STREAM/DONE.
//  - echo_out = buf[cell_count-1] when cell_count>0, else 0. It updates the cycle after a commit or erase.
//  - Reset mid-stream: braille_valid drops on the next edge and the buffer is emptied.
//  - rd_idx is 8-bit. Because braille_size<=MAX_CELLS<=255, there is no wrap.
// CONFIGURATION
//  BRAILLE_EIGHT_DOT_EN
//   - Defined: the full 8-bit dots_in is stored (8-dot computer braille).
//   - Undefined: bits 7:6 are forced to 0 on commit (6-dot braille).
//   - echo_out and the stream carry the stored value.
// STRUCTURE
//  - braille_pkg holds:
//    - state encodings IDLE/HEADER/STREAM/DONE
//    - BRAILLE_START 8'h17, BRAILLE_END 8'h01 and the HEADER pad byte 8'h00
//    - DOT6_MASK 8'h3F
//  - Sub-module btn_fall_detect (sync + falling-edge pulse) is instantiated 3x for enter/erase/send.
// TESTING
//  1 Reset, enter 0x01,0x03,0x09, send
//    -> valid high for 4 cycles: 0x00,0x01,0x03,0x09; size=3 throughout.
//    -> then cell_count=0, busy=0.
//  2 Enter 0x05, 0x07, erase, send
//    -> stream 0x00,0x05; size=1; echo_out was 0x07 then 0x05.
//  3 Send with empty buffer
//    -> no valid pulse; busy stays 0.
//    -> enter+erase pulses in the same cycle with 1 cell stored: cell_count 1->0.
//  4 MAX_CELLS=4: enter 5 cells
//    -> full=1, cell_count=4, 5th cell dropped.
//    -> send streams exactly 5 valid cycles.
//  5 dots_in=0xFF committed
//    -> stored 0x3F without BRAILLE_EIGHT_DOT_EN, 0xFF with it.
//  6 Assert reset during the STREAM cycle 2 of 5
//    -> valid=0 and cell_count=0 next cycle.
//    -> button presses during STREAM have no effect.

Source files
------------

// File: rtl/braille_pkg.sv
// rtl/braille_pkg.sv - shared state encoding and byte constants for the braille writer
package braille_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] BRAILLE_START = 8'h17;
    localparam logic [7:0] BRAILLE_END   = 8'h01;
    localparam logic [7:0] HEADER_PAD    = 8'h00;
    localparam logic [7:0] DOT6_MASK     = 8'h3F;

endpackage

// File: rtl/braille_writer_if.sv
// rtl/braille_writer_if.sv - cell stream bundle from the writer to the braille reader
interface braille_writer_if;
    logic [7:0] braille_out;
    logic [7:0] braille_size;
    logic       braille_valid;

    modport master (output braille_out, braille_size, braille_valid);
    modport slave  (input  braille_out, braille_size, braille_valid);
endinterface

// File: rtl/btn_fall_detect.sv
// rtl/btn_fall_detect.sv - two-flop button synchroniser with a one-cycle falling-edge pulse
module btn_fall_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            sync <= btn;
            prev <= sync;
        end
    end

    assign pulse = prev & ~sync;
endmodule

// File: rtl/braille_writer.sv
// rtl/braille_writer.sv - cell capture buffer and header+data streamer; BRAILLE_EIGHT_DOT_EN keeps dots 7/8
module braille_writer
    import braille_pkg::*;
#(
    parameter int MAX_CELLS = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       dots_in,
    input  logic             enter,
    input  logic             erase,
    input  logic             send,
    braille_writer_if.master stream,
    output logic [7:0]       echo_out,
    output logic [7:0]       cell_count,
    output logic             full,
    output logic             busy
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_CELLS);

    state_t     state;
    logic [7:0] rd_idx;
    logic [7:0] commit_val;
    logic       enter_ev, erase_ev, send_ev;
    logic       send_go, erase_go, enter_go;

    // Sized to the full 8-bit index range so counters address it directly.
    logic [7:0] cell_buf [256];

    btn_fall_detect u_enter (.clk(clk), .reset(reset), .btn(enter), .pulse(enter_ev));
    btn_fall_detect u_erase (.clk(clk), .reset(reset), .btn(erase), .pulse(erase_ev));
    btn_fall_detect u_send  (.clk(clk), .reset(reset), .btn(send),  .pulse(send_ev));

`ifdef BRAILLE_EIGHT_DOT_EN
    assign commit_val = dots_in;
`else
    assign commit_val = dots_in & DOT6_MASK;
`endif

    assign full = (cell_count == MAX_CNT);
    assign busy = (state != IDLE);

    // Send beats erase beats enter; an ignored send lets the others through.
    assign send_go  = (state == IDLE) && send_ev && (cell_count != 8'd0);
    assign erase_go = (state == IDLE) && !send_go && erase_ev && (cell_count != 8'd0);
    assign enter_go = (state == IDLE) && !send_go && !erase_go && enter_ev && !full;

    always_ff @(posedge clk) begin
        if (enter_go && !reset) begin
            cell_buf[cell_count] <= commit_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            cell_count           <= 8'd0;
            rd_idx               <= 8'd0;
            echo_out             <= 8'd0;
            stream.braille_out   <= 8'd0;
            stream.braille_size  <= 8'd0;
            stream.braille_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (send_go) begin
                        state                <= HEADER;
                        stream.braille_size  <= cell_count;
                        stream.braille_valid <= 1'b1;
                        stream.braille_out   <= HEADER_PAD;
                    end else if (erase_go) begin
                        cell_count <= cell_count - 8'd1;
                        echo_out   <= (cell_count > 8'd1) ? cell_buf[cell_count - 8'd2] : 8'd0;
                    end else if (enter_go) begin
                        cell_count <= cell_count + 8'd1;
                        echo_out   <= commit_val;
                    end
                end
                // Data is prefetched one cycle ahead so the output stays registered.
                HEADER: begin
                    stream.braille_out <= cell_buf[8'd0];
                    rd_idx             <= 8'd1;
                    state              <= STREAM;
                end
                STREAM: begin
                    if (rd_idx == stream.braille_size) begin
                        state                <= DONE;
                        stream.braille_valid <= 1'b0;
                        stream.braille_out   <= 8'd0;
                        stream.braille_size  <= 8'd0;
                        cell_count           <= 8'd0;
                        echo_out             <= 8'd0;
                    end else begin
                        stream.braille_out <= cell_buf[rd_idx];
                        rd_idx             <= rd_idx + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_braille_writer.sv
// tb/tb_braille_writer.sv - randomized bench for braille_writer against a queue-based message model
module tb_braille_writer;
    localparam int MAXC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dots_in;
    logic       enter, erase, send;
    logic [7:0] echo_out, cell_count;
    logic       full, busy;

    braille_writer_if bif ();

    braille_writer #(.MAX_CELLS(MAXC)) dut (
        .clk        (clk),
        .reset      (reset),
        .dots_in    (dots_in),
        .enter      (enter),
        .erase      (erase),
        .send       (send),
        .stream     (bif.master),
        .echo_out   (echo_out),
        .cell_count (cell_count),
        .full       (full),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] msg[$];
    logic [7:0] seen_data[$];
    logic [7:0] seen_size[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] stored(input logic [7:0] d);
`ifdef BRAILLE_EIGHT_DOT_EN
        return d;
`else
        return d & 8'h3F;
`endif
    endfunction

    always @(negedge clk) begin
        if (bif.braille_valid) begin
            seen_data.push_back(bif.braille_out);
            seen_size.push_back(bif.braille_size);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_count"}, 32'(cell_count), 32'(msg.size()));
        check({tag, "_echo"}, 32'(echo_out), (msg.size() > 0) ? 32'(msg[msg.size()-1]) : 32'd0);
        check({tag, "_full"}, 32'(full), 32'(msg.size() == MAXC));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Press and release buttons together; the model applies the resulting event.
    task automatic press(input bit e, input bit r, input logic [7:0] d);
        dots_in = d;
        enter = e; erase = r;
        tick(2);
        enter = 1'b0; erase = 1'b0;
        tick(4);
        if (r && msg.size() > 0) void'(msg.pop_back());
        else if (e && msg.size() < MAXC) msg.push_back(stored(d));
        check_idle(e && r ? "both" : (r ? "erase" : "enter"));
    endtask

    task automatic do_send(input bit poke);
        int cyc;
        seen_data.delete();
        seen_size.delete();
        send = 1'b1;
        tick(2);
        send = 1'b0;
        if (poke) begin
            cyc = 0;
            while (!bif.braille_valid && cyc < 20) begin tick(1); cyc++; end
            enter = 1'b1; erase = 1'b1; dots_in = 8'h2A;
            tick(1);
            enter = 1'b0; erase = 1'b0;
        end
        cyc = 0;
        tick(3);
        while (busy && cyc < 40) begin tick(1); cyc++; end
        check("send_timeout", 32'(cyc < 40), 32'd1);
        tick(2);
        if (msg.size() == 0) begin
            check("empty_send_valid", 32'(seen_data.size()), 32'd0);
        end else begin
            check("stream_len", 32'(seen_data.size()), 32'(msg.size() + 1));
            if (seen_data.size() == msg.size() + 1) begin
                check("stream_hdr", 32'(seen_data[0]), 32'h00);
                for (int i = 0; i < msg.size(); i++) check("stream_data", 32'(seen_data[i+1]), 32'(msg[i]));
                for (int i = 0; i < seen_size.size(); i++) check("stream_size", 32'(seen_size[i]), 32'(msg.size()));
            end
            msg.delete();
        end
        check_idle("after_send");
    endtask

    initial begin
        int cnt;
        reset = 1'b1; enter = 1'b0; erase = 1'b0; send = 1'b0; dots_in = 8'h00;
        tick(3);
        check("rst_valid", 32'(bif.braille_valid), 32'd0);
        check("rst_out", 32'(bif.braille_out), 32'd0);
        check("rst_size", 32'(bif.braille_size), 32'd0);
        check_idle("rst");
        reset = 1'b0;
        tick(2);

        press(1, 0, 8'h01); press(1, 0, 8'h03); press(1, 0, 8'h09);
        do_send(0);

        press(1, 0, 8'h05); press(1, 0, 8'h07); press(0, 1, 8'h00);
        do_send(0);

        do_send(0);
        press(1, 0, 8'h11); press(1, 1, 8'h22);

        for (int i = 0; i < 5; i++) press(1, 0, 8'($urandom));
        do_send(1);

        press(1, 0, 8'hFF);
        check("dot_mask", 32'(echo_out), 32'(stored(8'hFF)));
        do_send(0);

        for (int i = 0; i < 4; i++) press(1, 0, 8'($urandom));
        send = 1'b1; tick(2); send = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            tick(1);
            if (bif.braille_valid) cnt++;
        end
        check("mid_reach", 32'(cnt), 32'd3);
        reset = 1'b1;
        tick(1);
        check("mid_rst_valid", 32'(bif.braille_valid), 32'd0);
        check("mid_rst_count", 32'(cell_count), 32'd0);
        reset = 1'b0;
        msg.delete();
        tick(2);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: press(1, 0, 8'($urandom));
                5, 6:          press(0, 1, 8'h00);
                7:             press(1, 1, 8'($urandom));
                default:       do_send(msg.size() >= 2 && $urandom_range(0, 1) == 1);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
